// File: rtl/gemm_tile_scheduler_pkg.sv
// gemm_tile_scheduler_pkg
// Shared types and constants for the tiled GEMM scheduler:
//   sched_state_t - scheduler FSM states
//   sched_cfg_t   - latched job descriptor (bases and tile counts)
//   tile_words()  - words per N x N tile
package gemm_tile_scheduler_pkg;

  localparam int SCHED_N      = 4;
  localparam int SCHED_DIM_W  = 16;
  localparam int SCHED_ADDR_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WB,
    WB_WAIT,
    FIN
  } sched_state_t;

  typedef struct packed {
    logic [SCHED_ADDR_W-1:0] x_base;
    logic [SCHED_ADDR_W-1:0] w_base;
    logic [SCHED_ADDR_W-1:0] out_base;
    logic [SCHED_DIM_W-1:0]  m_tiles;
    logic [SCHED_DIM_W-1:0]  k_tiles;
    logic [SCHED_DIM_W-1:0]  n_tiles;
  } sched_cfg_t;

  function automatic int tile_words(input int n);
    return n * n;
  endfunction

endpackage

// File: rtl/gemm_tile_scheduler_tile_addr_gen.sv
// tile_addr_gen
// Registers the X, W and C tile word addresses for the current (m, n, k)
// tile triple. The multiply/add path ends in a register so it never sits
// in series with the scheduler FSM.
// Ports:
//   clk, n_rst            clock, async active-low reset
//   i_m, i_n, i_k         current tile indices
//   i_cfg                 latched job descriptor
//   o_x_addr, o_w_addr    operand tile addresses (one cycle after inputs)
//   o_wb_addr             output tile address   (one cycle after inputs)
module tile_addr_gen
  import gemm_tile_scheduler_pkg::*;
#(
  parameter int N = SCHED_N
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [SCHED_DIM_W-1:0]  i_m,
  input  logic [SCHED_DIM_W-1:0]  i_n,
  input  logic [SCHED_DIM_W-1:0]  i_k,
  input  sched_cfg_t              i_cfg,
  output logic [SCHED_ADDR_W-1:0] o_x_addr,
  output logic [SCHED_ADDR_W-1:0] o_w_addr,
  output logic [SCHED_ADDR_W-1:0] o_wb_addr
);

  localparam logic [SCHED_ADDR_W-1:0] TILE_WORDS = SCHED_ADDR_W'(tile_words(N));

  logic [SCHED_ADDR_W-1:0] w_xIndex;
  logic [SCHED_ADDR_W-1:0] w_wIndex;
  logic [SCHED_ADDR_W-1:0] w_cIndex;
  logic [SCHED_ADDR_W-1:0] r_xAddr;
  logic [SCHED_ADDR_W-1:0] r_wAddr;
  logic [SCHED_ADDR_W-1:0] r_wbAddr;

  // Tile indices in row-major tile order; everything wraps at ADDR_W bits.
  assign w_xIndex = SCHED_ADDR_W'(i_m) * SCHED_ADDR_W'(i_cfg.k_tiles) + SCHED_ADDR_W'(i_k);
  assign w_wIndex = SCHED_ADDR_W'(i_k) * SCHED_ADDR_W'(i_cfg.n_tiles) + SCHED_ADDR_W'(i_n);
  assign w_cIndex = SCHED_ADDR_W'(i_m) * SCHED_ADDR_W'(i_cfg.n_tiles) + SCHED_ADDR_W'(i_n);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_xAddr  <= '0;
      r_wAddr  <= '0;
      r_wbAddr <= '0;
    end else begin
      r_xAddr  <= i_cfg.x_base   + w_xIndex * TILE_WORDS;
      r_wAddr  <= i_cfg.w_base   + w_wIndex * TILE_WORDS;
      r_wbAddr <= i_cfg.out_base + w_cIndex * TILE_WORDS;
    end
  end

  assign o_x_addr  = r_xAddr;
  assign o_w_addr  = r_wAddr;
  assign o_wb_addr = r_wbAddr;

endmodule

// File: rtl/gemm_tile_scheduler.sv
// gemm_tile_scheduler
// Walks every (m, n, k) tile triple of a tiled GEMM (m outer, n middle,
// k inner), launching one systolic-array multiply per triple and one
// writeback per output tile.
// Ports:
//   clk, n_rst                   clock, async active-low reset
//   cfg_*                        job descriptor handshake and fields
//   x_addr, w_addr, acc_clear,
//   start_mul, stall_mul,
//   mul_done                     systolic array control
//   wb_valid, wb_ready, wb_addr,
//   wb_done                      writeback request and completion
//   busy, done, cfg_err,
//   tiles_done                   job status
// Optional build macro SCHED_WATCHDOG_EN adds timeout_err and a 16-bit
// watchdog that aborts a job stuck in WAIT or WB_WAIT.
module gemm_tile_scheduler
  import gemm_tile_scheduler_pkg::*;
#(
  parameter int N      = SCHED_N,
  parameter int DIM_W  = SCHED_DIM_W,
  parameter int ADDR_W = SCHED_ADDR_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_x_base,
  input  logic [ADDR_W-1:0] cfg_w_base,
  input  logic [ADDR_W-1:0] cfg_out_base,
  input  logic [DIM_W-1:0]  cfg_m_tiles,
  input  logic [DIM_W-1:0]  cfg_k_tiles,
  input  logic [DIM_W-1:0]  cfg_n_tiles,
  output logic [ADDR_W-1:0] x_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic              acc_clear,
  output logic              start_mul,
  input  logic              stall_mul,
  input  logic              mul_done,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  input  logic              wb_done,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [31:0]       tiles_done
`ifdef SCHED_WATCHDOG_EN
  ,
  output logic              timeout_err
`endif
);

  localparam logic [SCHED_DIM_W-1:0] DIM_ONE = SCHED_DIM_W'(1);

  sched_state_t           r_state;
  sched_cfg_t             r_cfg;
  sched_cfg_t             w_cfgIn;
  logic [SCHED_DIM_W-1:0] r_m;
  logic [SCHED_DIM_W-1:0] r_n;
  logic [SCHED_DIM_W-1:0] r_k;
  logic                   r_cfgReady;
  logic                   r_startMul;
  logic                   r_accClear;
  logic                   r_wbValid;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_cfgErr;
  logic [31:0]            r_tilesDone;
  logic                   w_cfgZero;

  assign w_cfgIn.x_base   = cfg_x_base;
  assign w_cfgIn.w_base   = cfg_w_base;
  assign w_cfgIn.out_base = cfg_out_base;
  assign w_cfgIn.m_tiles  = cfg_m_tiles;
  assign w_cfgIn.k_tiles  = cfg_k_tiles;
  assign w_cfgIn.n_tiles  = cfg_n_tiles;

  assign w_cfgZero = (cfg_m_tiles == '0) || (cfg_k_tiles == '0) || (cfg_n_tiles == '0);

`ifdef SCHED_WATCHDOG_EN
  logic [15:0]  r_wdog;
  sched_state_t r_prevState;
  logic         r_timeoutErr;
  logic         w_timeout;

  // The counter restarts whenever the state changed on the previous edge
  // and saturates so a stuck job keeps reporting the timeout condition.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wdog      <= '0;
      r_prevState <= IDLE;
    end else begin
      r_prevState <= r_state;
      if (r_state != r_prevState) begin
        r_wdog <= '0;
      end else if (r_wdog != 16'hFFFF) begin
        r_wdog <= r_wdog + 16'd1;
      end
    end
  end

  assign w_timeout   = ((r_state == WAIT) || (r_state == WB_WAIT)) && (r_wdog == 16'hFFFF);
  assign timeout_err = r_timeoutErr;
`endif

  // Pulses (start_mul, acc_clear, done) default low every cycle so each
  // assertion lasts exactly one cycle. Counters only move on mul_done in
  // WAIT and wb_done in WB_WAIT, which keeps the registered addresses
  // stable across each multiply.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_cfg       <= '0;
      r_m         <= '0;
      r_n         <= '0;
      r_k         <= '0;
      r_cfgReady  <= 1'b1;
      r_startMul  <= 1'b0;
      r_accClear  <= 1'b0;
      r_wbValid   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfgErr    <= 1'b0;
      r_tilesDone <= '0;
`ifdef SCHED_WATCHDOG_EN
      r_timeoutErr <= 1'b0;
`endif
    end else begin
      r_startMul <= 1'b0;
      r_accClear <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cfg_valid) begin
            r_cfg       <= w_cfgIn;
            r_m         <= '0;
            r_n         <= '0;
            r_k         <= '0;
            r_tilesDone <= '0;
            r_cfgReady  <= 1'b0;
`ifdef SCHED_WATCHDOG_EN
            r_timeoutErr <= 1'b0;
`endif
            if (w_cfgZero) begin
              r_cfgErr <= 1'b1;
              r_done   <= 1'b1;
              r_state  <= FIN;
            end else begin
              r_cfgErr <= 1'b0;
              r_busy   <= 1'b1;
              r_state  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (!stall_mul) begin
            r_startMul <= 1'b1;
            r_accClear <= (r_k == '0);
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          if (mul_done) begin
            if (r_k == r_cfg.k_tiles - DIM_ONE) begin
              r_wbValid <= 1'b1;
              r_state   <= WB;
            end else begin
              r_k     <= r_k + DIM_ONE;
              r_state <= ISSUE;
            end
          end
        end
        WB: begin
          if (wb_ready) begin
            r_wbValid <= 1'b0;
            r_state   <= WB_WAIT;
          end
        end
        WB_WAIT: begin
          if (wb_done) begin
            r_tilesDone <= r_tilesDone + 32'd1;
            r_k         <= '0;
            if (r_n == r_cfg.n_tiles - DIM_ONE) begin
              r_n <= '0;
              if (r_m == r_cfg.m_tiles - DIM_ONE) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= FIN;
              end else begin
                r_m     <= r_m + DIM_ONE;
                r_state <= ISSUE;
              end
            end else begin
              r_n     <= r_n + DIM_ONE;
              r_state <= ISSUE;
            end
          end
        end
        FIN: begin
          r_cfgReady <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
`ifdef SCHED_WATCHDOG_EN
      // A stuck array or writeback engine abandons the job through FIN.
      if (w_timeout) begin
        r_timeoutErr <= 1'b1;
        r_wbValid    <= 1'b0;
        r_busy       <= 1'b0;
        r_done       <= 1'b1;
        r_state      <= FIN;
      end
`endif
    end
  end

  tile_addr_gen #(
    .N(N)
  ) u_addr_gen (
    .clk       (clk),
    .n_rst     (n_rst),
    .i_m       (r_m),
    .i_n       (r_n),
    .i_k       (r_k),
    .i_cfg     (r_cfg),
    .o_x_addr  (x_addr),
    .o_w_addr  (w_addr),
    .o_wb_addr (wb_addr)
  );

  assign cfg_ready  = r_cfgReady;
  assign start_mul  = r_startMul;
  assign acc_clear  = r_accClear;
  assign wb_valid   = r_wbValid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign cfg_err    = r_cfgErr;
  assign tiles_done = r_tilesDone;

endmodule
